// File: rtl/phy_read_sequencer.sv
// phy_read_sequencer: READ capture/drain sequencing for one PHY channel.
// Optional drain watchdog is built when READSEQ_TIMEOUT_EN is defined.
module phy_read_sequencer #(
  parameter int BURST_LENGTH  = 8,
  parameter int READ_LATENCY  = 11,
  parameter int MAX_INFLIGHT  = 4,
  parameter int TAG_WIDTH     = 4,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdCmdValid,
  input  logic [TAG_WIDTH-1:0]          rdCmdTag,
  output logic                          rdCmdReady,
  output logic                          captureFlag,
  input  logic                          captureAck,
  input  logic                          drainReady,
  output logic                          drainFlag,
  output logic                          drainLast,
  output logic [TAG_WIDTH-1:0]          drainTag,
  output logic [$clog2(MAX_INFLIGHT):0] inflightCnt,
  output logic                          seqError,
  output logic                          drainTimeout
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam int BW = $clog2(BURST_LENGTH);
  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int PD = READ_LATENCY - 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LENGTH - 1);

  typedef enum logic {S_IDLE, S_DRAIN} dstate_e;

  logic                 accept;
  logic                 capStart;
  logic                 capLast;
  logic [BW-1:0]        gap_q, gap_d;
  logic [PD-1:0]        pv_q;
  logic [TAG_WIDTH-1:0] pt_q [PD];
  logic                 cap_q, cap_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [TAG_WIDTH-1:0] ctag_q, ctag_d;
  logic [TAG_WIDTH-1:0] mem_q [MAX_INFLIGHT];
  logic [PW-1:0]        wp_q, rp_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        infl_q, infl_d;
  logic [CW-1:0]        ack_q, ack_d;
  logic                 err_q, err_d;
  dstate_e              st_q, st_d;
  logic [BW-1:0]        db_q, db_d;

  assign rdCmdReady  = (infl_q < CW'(MAX_INFLIGHT)) && (gap_q == '0);
  assign accept      = rdCmdValid && rdCmdReady;
  assign capStart    = pv_q[PD-1];
  assign capLast     = cap_q && (beat_q == BEAT_LAST);
  assign captureFlag = cap_q;
  assign drainFlag   = (st_q == S_DRAIN);
  assign drainLast   = drainFlag && (db_q == BEAT_LAST);
  assign drainTag    = mem_q[rp_q];
  assign inflightCnt = infl_q;
  assign seqError    = err_q;

  always_comb begin
    gap_d = gap_q;
    if (accept) gap_d = BEAT_LAST;
    else if (gap_q != '0) gap_d = gap_q - BW'(1);
  end

  always_comb begin
    cap_d  = cap_q;
    beat_d = beat_q;
    ctag_d = ctag_q;
    if (capStart) begin
      cap_d  = 1'b1;
      beat_d = '0;
      ctag_d = pt_q[PD-1];
    end else if (cap_q) begin
      beat_d = beat_q + BW'(1);
      if (capLast) cap_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d  = cnt_q + CW'(capLast) - CW'(drainLast);
    infl_d = infl_q + CW'(accept) - CW'(drainLast);
    ack_d  = ack_q;
    err_d  = err_q;
    if (capLast && !captureAck) begin
      if (ack_q != '1) ack_d = ack_q + CW'(1);
    end else if (!capLast && captureAck) begin
      if (ack_q != '0) ack_d = ack_q - CW'(1);
      else err_d = 1'b1;
    end
  end

  // A further burst chains only if already queued and the buffer is ready.
  always_comb begin
    st_d = st_q;
    db_d = db_q;
    unique case (st_q)
      S_IDLE: begin
        if (cnt_q != '0 && drainReady) begin
          st_d = S_DRAIN;
          db_d = '0;
        end
      end
      S_DRAIN: begin
        db_d = db_q + BW'(1);
        if (drainLast && !(cnt_q > CW'(1) && drainReady))
          st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv_q <= '0;
      for (int i = 0; i < PD; i++) pt_q[i] <= '0;
    end else begin
      pv_q[0] <= accept;
      pt_q[0] <= rdCmdTag;
      for (int i = 1; i < PD; i++) begin
        pv_q[i] <= pv_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_q  <= '0;
      cap_q  <= 1'b0;
      beat_q <= '0;
      ctag_q <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
      ack_q  <= '0;
      err_q  <= 1'b0;
      st_q   <= S_IDLE;
      db_q   <= '0;
    end else begin
      gap_q  <= gap_d;
      cap_q  <= cap_d;
      beat_q <= beat_d;
      ctag_q <= ctag_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      st_q   <= st_d;
      db_q   <= db_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) mem_q[i] <= '0;
    end else begin
      if (capLast) begin
        mem_q[wp_q] <= ctag_q;
        wp_q        <= wp_q + PW'(1);
      end
      if (drainLast) rp_q <= rp_q + PW'(1);
    end
  end

`ifdef READSEQ_TIMEOUT_EN
  localparam int TOW = $clog2(DRAIN_TIMEOUT + 1);

  logic [TOW-1:0] to_q, to_d;
  logic           tof_q, tof_d;

  // Runs only while a burst waits in IDLE and no drain starts this cycle.
  always_comb begin
    to_d  = '0;
    tof_d = tof_q;
    if (st_q == S_IDLE && cnt_q != '0 && !drainReady) begin
      to_d = to_q;
      if (to_q != TOW'(DRAIN_TIMEOUT)) to_d = to_q + TOW'(1);
      if (to_q == TOW'(DRAIN_TIMEOUT - 1)) tof_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q  <= '0;
      tof_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      tof_q <= tof_d;
    end
  end

  assign drainTimeout = tof_q;
`else
  assign drainTimeout = (DRAIN_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_phy_read_sequencer.sv
// tb_phy_read_sequencer: directed vectors plus a cycle-level behavioural model.
// Watchdog expectations follow READSEQ_TIMEOUT_EN.
module tb_phy_read_sequencer;

  localparam int BL = 8;
  localparam int RL = 11;
  localparam int MI = 4;
  localparam int TW = 4;
  localparam int DT = 16;
`ifdef READSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rdCmdValid = 1'b0;
  logic [TW-1:0] rdCmdTag = '0;
  logic          rdCmdReady;
  logic          captureFlag;
  logic          captureAck = 1'b0;
  logic          drainReady = 1'b0;
  logic          drainFlag;
  logic          drainLast;
  logic [TW-1:0] drainTag;
  logic [2:0]    inflightCnt;
  logic          seqError;
  logic          drainTimeout;

  phy_read_sequencer #(
    .BURST_LENGTH (BL),
    .READ_LATENCY (RL),
    .MAX_INFLIGHT (MI),
    .TAG_WIDTH    (TW),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdCmdValid  (rdCmdValid),
    .rdCmdTag    (rdCmdTag),
    .rdCmdReady  (rdCmdReady),
    .captureFlag (captureFlag),
    .captureAck  (captureAck),
    .drainReady  (drainReady),
    .drainFlag   (drainFlag),
    .drainLast   (drainLast),
    .drainTag    (drainTag),
    .inflightCnt (inflightCnt),
    .seqError    (seqError),
    .drainTimeout(drainTimeout)
  );

  always #5 clk = ~clk;

  int cyc_raw = 0;
  int base = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc_raw <= cyc_raw + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc_raw - base);
    end
  endtask

  task automatic at(int n);
    while (cyc_raw - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdCmdValid = 1'b0;
    captureAck = 1'b0;
    drainReady = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    base = cyc_raw;
  endtask

  task automatic issue(int n, int tag);
    at(n);
    rdCmdValid = 1'b1;
    rdCmdTag = TW'(tag);
    at(n + 1);
    rdCmdValid = 1'b0;
  endtask

  task automatic ack_at(int n);
    at(n);
    captureAck = 1'b1;
    at(n + 1);
    captureAck = 1'b0;
  endtask

  // Model: accepted READs by time, queued tags with visibility time,
  // and a drain window described by its start cycle.
  typedef struct {
    int tag;
    int vis;
  } qe_t;

  qe_t dq[$];
  int  accT[$];
  int  accTag[$];
  int  m_infl, m_ack, m_gap, m_ds, m_to;
  bit  m_err, m_dact, m_tof;

  always @(negedge clk) begin : model
    int c, vc, lcTag;
    bit eR, eC, eL, acc, lastCap, startD, wasIdle;
    c = cyc_raw;
    if (!rst) begin
      dq.delete();
      accT.delete();
      accTag.delete();
      m_infl = 0; m_ack = 0; m_gap = 0; m_ds = 0; m_to = 0;
      m_err = 0; m_dact = 0; m_tof = 0;
      chk("rst_cap", captureFlag, 0);
      chk("rst_dflag", drainFlag, 0);
      chk("rst_dlast", drainLast, 0);
      chk("rst_infl", inflightCnt, 0);
      chk("rst_err", seqError, 0);
      chk("rst_to", drainTimeout, 0);
    end else begin
      eR = (m_infl < MI) && (c >= m_gap);
      eC = 1'b0;
      foreach (accT[i])
        if (c >= accT[i] + RL && c <= accT[i] + RL + BL - 1) eC = 1'b1;
      eL = m_dact && (c == m_ds + BL - 1);
      chk("m_ready", rdCmdReady, eR);
      chk("m_cap", captureFlag, eC);
      chk("m_dflag", drainFlag, m_dact);
      chk("m_dlast", drainLast, eL);
      if (m_dact && dq.size() > 0) chk("m_dtag", drainTag, dq[0].tag);
      chk("m_infl", inflightCnt, m_infl);
      chk("m_err", seqError, m_err);
      chk("m_to", drainTimeout, m_tof);

      acc = rdCmdValid && eR;
      lastCap = 1'b0;
      lcTag = 0;
      foreach (accT[i])
        if (accT[i] + RL + BL - 1 == c) begin
          lastCap = 1'b1;
          lcTag = accTag[i];
        end
      vc = 0;
      foreach (dq[i]) if (dq[i].vis <= c) vc++;
      wasIdle = !m_dact;
      startD = 1'b0;
      if (m_dact) begin
        if (eL) begin
          void'(dq.pop_front());
          if (vc > 1 && drainReady) m_ds = c + 1;
          else m_dact = 1'b0;
        end
      end else if (vc > 0 && drainReady) begin
        m_dact = 1'b1;
        m_ds = c + 1;
        startD = 1'b1;
      end
      if (wasIdle && vc > 0 && !startD) begin
        m_to++;
        if (TO_EN && m_to == DT) m_tof = 1'b1;
      end else begin
        m_to = 0;
      end
      if (captureAck && !lastCap) begin
        if (m_ack > 0) m_ack--;
        else m_err = 1'b1;
      end else if (lastCap && !captureAck) begin
        m_ack++;
      end
      if (lastCap) dq.push_back('{tag: lcTag, vis: c + 1});
      m_infl = m_infl + int'(acc) - int'(eL);
      if (acc) begin
        accT.push_back(c);
        accTag.push_back(int'(rdCmdTag));
        m_gap = c + BL;
      end
      for (int i = accT.size() - 1; i >= 0; i--)
        if (accT[i] + RL + BL - 1 <= c) begin
          accT.delete(i);
          accTag.delete(i);
        end
    end
  end

  initial begin
    int nf, nl;
    // 1: single READ
    do_reset();
    chk("t1_ready0", rdCmdReady, 1);
    drainReady = 1'b1;
    issue(10, 3);
    chk("t1_infl11", inflightCnt, 1);
    at(20); chk("t1_cap20", captureFlag, 0);
    at(21); chk("t1_cap21", captureFlag, 1);
    at(28); chk("t1_cap28", captureFlag, 1);
    at(29); chk("t1_cap29", captureFlag, 0);
    chk("t1_df29", drainFlag, 0);
    ack_at(29);
    chk("t1_df30", drainFlag, 1);
    chk("t1_tag30", drainTag, 3);
    at(36); chk("t1_dl36", drainLast, 0);
    at(37); chk("t1_dl37", drainLast, 1);
    chk("t1_infl37", inflightCnt, 1);
    at(38); chk("t1_df38", drainFlag, 0);
    chk("t1_infl38", inflightCnt, 0);
    chk("t1_err", seqError, 0);

    // 2: gap blocking and re-present
    do_reset();
    drainReady = 1'b1;
    issue(10, 5);
    chk("t2_rdy11", rdCmdReady, 0);
    issue(13, 6);
    chk("t2_infl14", inflightCnt, 1);
    at(17); chk("t2_rdy17", rdCmdReady, 0);
    at(18); chk("t2_rdy18", rdCmdReady, 1);
    issue(18, 7);
    ack_at(29);
    at(36); chk("t2_cap36", captureFlag, 1);
    ack_at(37);
    chk("t2_cap38", captureFlag, 0);
    at(38); chk("t2_tag38", drainTag, 7);
    at(46); chk("t2_infl46", inflightCnt, 0);

    // 3: four READs held, then back-to-back drain
    do_reset();
    issue(10, 0);
    issue(18, 1);
    issue(26, 2);
    ack_at(29);
    at(34); chk("t3_rdy34", rdCmdReady, 1);
    issue(34, 3);
    chk("t3_rdy35", rdCmdReady, 0);
    chk("t3_infl35", inflightCnt, 4);
    ack_at(37);
    ack_at(45);
    ack_at(53);
    at(60); chk("t3_df60", drainFlag, 0);
    drainReady = 1'b1;
    nf = 0;
    nl = 0;
    for (int c = 61; c <= 92; c++) begin
      at(c);
      if (drainFlag) nf++;
      if (drainLast) nl++;
      if ((c - 61) % 8 == 0) chk("t3_tag", drainTag, (c - 61) / 8);
    end
    chk("t3_nflag", nf, 32);
    chk("t3_nlast", nl, 4);
    at(93); chk("t3_df93", drainFlag, 0);
    chk("t3_infl93", inflightCnt, 0);

    // 4: spurious ACK
    do_reset();
    drainReady = 1'b1;
    ack_at(5);
    chk("t4_err6", seqError, 1);
    issue(10, 9);
    ack_at(29);
    chk("t4_df30", drainFlag, 1);
    chk("t4_tag30", drainTag, 9);
    at(40); chk("t4_err40", seqError, 1);

    // 5: reset mid-capture
    do_reset();
    drainReady = 1'b1;
    issue(10, 4);
    at(24); chk("t5_cap24", captureFlag, 1);
    rst = 1'b0;
    #1;
    chk("t5_cap_rst", captureFlag, 0);
    chk("t5_infl_rst", inflightCnt, 0);
    chk("t5_df_rst", drainFlag, 0);
    at(26);
    rst = 1'b1;
    chk("t5_rdy", rdCmdReady, 1);
    nf = 0;
    for (int c = 27; c <= 60; c++) begin
      at(c);
      if (drainFlag) nf++;
    end
    chk("t5_nodrain", nf, 0);

    // 6: drain watchdog
    do_reset();
    issue(10, 2);
    ack_at(29);
    at(44); chk("t6_to44", drainTimeout, 0);
    at(45); chk("t6_to45", drainTimeout, TO_EN);
    at(60); chk("t6_to60", drainTimeout, TO_EN);
    drainReady = 1'b1;
    at(61); chk("t6_df61", drainFlag, 1);
    at(70); chk("t6_to70", drainTimeout, TO_EN);
    chk("t6_infl70", inflightCnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
